vga_bus_ctrl: RTL and testbench



---
 rtl/vga_bus_ctrl_pkg.sv | 32 +++
 rtl/vga_clear_seq.sv | 51 +++++
 rtl/vga_bus_ctrl.sv | 140 ++++++++++++++
 tb/tb_vga_bus_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_bus_ctrl_pkg.sv
// Shared definitions for the VGA bus front end: register map, CTRL bits,
// clear-sweep FSM states and reset colour pair.
package vga_bus_ctrl_pkg;

    localparam int unsigned BUS_W    = 8;
    localparam int unsigned COL_W    = 16;
    localparam int unsigned NUM_REGS = 7;

    localparam logic [BUS_W-1:0] REG_X         = 8'd0;
    localparam logic [BUS_W-1:0] REG_Y         = 8'd1;
    localparam logic [BUS_W-1:0] REG_PIXEL     = 8'd2;
    localparam logic [BUS_W-1:0] REG_CTRL      = 8'd3;
    localparam logic [BUS_W-1:0] REG_COLOUR_LO = 8'd4;
    localparam logic [BUS_W-1:0] REG_COLOUR_HI = 8'd5;
    localparam logic [BUS_W-1:0] REG_FILL      = 8'd6;

    localparam int unsigned CTRL_AUTO_INC = 0;
    localparam int unsigned CTRL_CLEAR    = 1;

    localparam logic [COL_W-1:0] COLOUR_RST = 16'h33CC;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } clr_state_e;

    // True when a base-relative offset lands inside the register window.
    function automatic logic reg_in_window(input logic [BUS_W-1:0] off);
        return off < BUS_W'(NUM_REGS);
    endfunction

endpackage

// File: rtl/vga_clear_seq.sv
// Clear-screen sweep: walks every frame-buffer address once, ascending,
// one per cycle after a start request; start is ignored while sweeping.
module vga_clear_seq
    import vga_bus_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    output logic              busy_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic              we_o
);

    clr_state_e        state_q;
    logic [ADDR_W-1:0] addr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        state_q <= ST_CLEAR;
                        addr_q  <= '0;
                    end
                end
                ST_CLEAR: begin
                    if (addr_q == '1) begin
                        state_q <= ST_IDLE;
                        addr_q  <= '0;
                    end else begin
                        addr_q <= addr_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    addr_q  <= '0;
                end
            endcase
        end
    end

    assign busy_o = (state_q == ST_CLEAR);
    assign we_o   = (state_q == ST_CLEAR);
    assign addr_o = addr_q;

endmodule

// File: rtl/vga_bus_ctrl.sv
// Bus-mapped VGA frame-buffer front end: register decode, X/Y cursor with
// auto-increment, colour pair, and frame-buffer port A write mux.
module vga_bus_ctrl
    import vga_bus_ctrl_pkg::*;
#(
    parameter logic [7:0]  BASE_ADDR = 8'hB0,
    parameter int unsigned X_W       = 8,
    parameter int unsigned Y_W       = 7,
    parameter int unsigned PIX_W     = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [BUS_W-1:0]     bus_addr_i,
    input  logic [BUS_W-1:0]     bus_data_i,
    input  logic                 bus_we_i,
    output logic [X_W+Y_W-1:0]   fb_addr_o,
    output logic [PIX_W-1:0]     fb_data_o,
    output logic                 fb_we_o,
    output logic [COL_W-1:0]     config_colours_o,
    output logic                 busy_o
);

    localparam int unsigned ADDR_W = X_W + Y_W;

    logic [BUS_W-1:0]  off_c;
    logic              hit_c;
    logic              wr_x_c, wr_y_c, wr_pixel_c, wr_ctrl_c;
    logic              wr_col_lo_c, wr_col_hi_c, wr_fill_c;
    logic              pix_c, clr_start_c;

    logic [X_W-1:0]    x_q;
    logic [Y_W-1:0]    y_q;
    logic              auto_inc_q;
    logic [PIX_W-1:0]  fill_q;
    logic [PIX_W-1:0]  fill_snap_q;
    logic [7:0]        col_lo_q;
    logic [7:0]        col_hi_q;
    logic              pix_we_q;
    logic [ADDR_W-1:0] pix_addr_q;
    logic [PIX_W-1:0]  pix_data_q;

    logic              clr_busy;
    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;

    // Address decode relative to the register window.
    always_comb begin
        off_c       = BUS_W'(bus_addr_i - BASE_ADDR);
        hit_c       = bus_we_i && reg_in_window(off_c);
        wr_x_c      = hit_c && (off_c == REG_X);
        wr_y_c      = hit_c && (off_c == REG_Y);
        wr_pixel_c  = hit_c && (off_c == REG_PIXEL);
        wr_ctrl_c   = hit_c && (off_c == REG_CTRL);
        wr_col_lo_c = hit_c && (off_c == REG_COLOUR_LO);
        wr_col_hi_c = hit_c && (off_c == REG_COLOUR_HI);
        wr_fill_c   = hit_c && (off_c == REG_FILL);
        pix_c       = wr_pixel_c && !clr_busy;
        clr_start_c = wr_ctrl_c && bus_data_i[CTRL_CLEAR];
    end

    vga_clear_seq #(
        .ADDR_W (ADDR_W)
    ) u_clear_seq (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (clr_start_c),
        .busy_o  (clr_busy),
        .addr_o  (clr_addr),
        .we_o    (clr_we)
    );

    // Cursor: explicit X/Y writes, or post-increment after an accepted pixel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            if (wr_x_c) begin
                x_q <= bus_data_i[X_W-1:0];
            end else if (pix_c && auto_inc_q) begin
                x_q <= x_q + 1'b1;
                if (x_q == '1) begin
                    y_q <= y_q + 1'b1;
                end
            end
            if (wr_y_c) begin
                y_q <= bus_data_i[Y_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            auto_inc_q  <= 1'b0;
            fill_q      <= '0;
            fill_snap_q <= '0;
            col_lo_q    <= COLOUR_RST[7:0];
            col_hi_q    <= COLOUR_RST[15:8];
        end else begin
            if (wr_ctrl_c) begin
                auto_inc_q <= bus_data_i[CTRL_AUTO_INC];
            end
            if (wr_fill_c) begin
                fill_q <= bus_data_i[PIX_W-1:0];
            end
            if (clr_start_c && !clr_busy) begin
                fill_snap_q <= fill_q;
            end
            if (wr_col_lo_c) begin
                col_lo_q <= bus_data_i;
            end
            if (wr_col_hi_c) begin
                col_hi_q <= bus_data_i;
            end
        end
    end

    // Pixel write port: address captured before the cursor advances.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_we_q   <= 1'b0;
            pix_addr_q <= '0;
            pix_data_q <= '0;
        end else begin
            pix_we_q <= pix_c;
            if (pix_c) begin
                pix_addr_q <= {y_q, x_q};
                pix_data_q <= bus_data_i[PIX_W-1:0];
            end
        end
    end

    // Sweep and pixel writes never overlap: pixels are dropped while busy.
    assign fb_we_o          = clr_we | pix_we_q;
    assign fb_addr_o        = clr_busy ? clr_addr : pix_addr_q;
    assign fb_data_o        = clr_busy ? fill_snap_q : pix_data_q;
    assign busy_o           = clr_busy;
    assign config_colours_o = {col_hi_q, col_lo_q};

endmodule

// File: tb/tb_vga_bus_ctrl.sv
// Self-checking bench for vga_bus_ctrl against a behavioural register/cursor model.
module tb_vga_bus_ctrl;

    localparam logic [7:0]  BASE   = 8'hB0;
    localparam int unsigned X_W    = 8;
    localparam int unsigned Y_W    = 7;
    localparam int unsigned PIX_W  = 1;
    localparam int unsigned ADDR_W = X_W + Y_W;
    localparam int          NPIX   = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [7:0]        bus_addr;
    logic [7:0]        bus_data;
    logic              bus_we;
    logic [ADDR_W-1:0] fb_addr_o;
    logic [PIX_W-1:0]  fb_data_o;
    logic              fb_we_o;
    logic [15:0]       config_colours_o;
    logic              busy_o;

    int checks = 0;
    int errors = 0;

    int         mx, my, mfill;
    bit         mauto;
    logic [15:0] mcol;

    always #5 clk = ~clk;

    vga_bus_ctrl #(
        .BASE_ADDR (BASE),
        .X_W       (X_W),
        .Y_W       (Y_W),
        .PIX_W     (PIX_W)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .bus_addr_i       (bus_addr),
        .bus_data_i       (bus_data),
        .bus_we_i         (bus_we),
        .fb_addr_o        (fb_addr_o),
        .fb_data_o        (fb_data_o),
        .fb_we_o          (fb_we_o),
        .config_colours_o (config_colours_o),
        .busy_o           (busy_o)
    );

    task automatic model_reset();
        mx = 0; my = 0; mauto = 0; mfill = 0; mcol = 16'h33CC;
    endtask

    // Register-level model of one bus write; returns the expected frame-buffer write.
    task automatic model_write(input logic [7:0] addr, input logic [7:0] data, input bit sweeping,
                               output bit ewe, output int eaddr, output int edata);
        int off;
        off = int'(addr) - int'(BASE);
        ewe = 0; eaddr = 0; edata = 0;
        case (off)
            0: mx = int'(data) % (1 << X_W);
            1: my = int'(data) % (1 << Y_W);
            2: if (!sweeping) begin
                ewe = 1;
                eaddr = my * (1 << X_W) + mx;
                edata = int'(data) % (1 << PIX_W);
                if (mauto) begin
                    mx = mx + 1;
                    if (mx == (1 << X_W)) begin
                        mx = 0;
                        my = (my + 1) % (1 << Y_W);
                    end
                end
            end
            3: mauto = data[0];
            4: mcol[7:0] = data;
            5: mcol[15:8] = data;
            6: mfill = int'(data) % (1 << PIX_W);
            default: ;
        endcase
    endtask

    task automatic bus_write(input logic [7:0] addr, input logic [7:0] data);
        @(negedge clk);
        bus_addr = addr; bus_data = data; bus_we = 1'b1;
        @(posedge clk);
        #1;
        bus_we = 1'b0;
    endtask

    task automatic test_reset();
        bit ewe; int ea, ed;
        bus_write(BASE + 8'd0, 8'h12);     model_write(BASE + 8'd0, 8'h12, 0, ewe, ea, ed);
        bus_write(BASE + 8'd3, 8'h01);     model_write(BASE + 8'd3, 8'h01, 0, ewe, ea, ed);
        bus_write(BASE + 8'd4, 8'h00);     model_write(BASE + 8'd4, 8'h00, 0, ewe, ea, ed);
        @(negedge clk);
        bus_addr = BASE + 8'd2; bus_data = 8'h01; bus_we = 1'b1;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        bus_we = 1'b0;
        #1;
        checks++; if (fb_we_o !== 1'b0) begin errors++; $display("FAIL reset_we got %b want 0", fb_we_o); end
        checks++; if (fb_addr_o !== '0) begin errors++; $display("FAIL reset_addr got %h want 0", fb_addr_o); end
        checks++; if (fb_data_o !== '0) begin errors++; $display("FAIL reset_data got %h want 0", fb_data_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy_o); end
        checks++; if (config_colours_o !== 16'h33CC) begin errors++; $display("FAIL reset_colours got %h want 33cc", config_colours_o); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        begin
            int spurious = 0;
            repeat (4) begin
                @(posedge clk); #1;
                if (fb_we_o !== 1'b0) spurious++;
            end
            checks++; if (spurious != 0) begin errors++; $display("FAIL reset_release_we got %0d writes want 0", spurious); end
        end
    endtask

    task automatic test_pixel();
        bit ewe; int ea, ed;
        bus_write(BASE + 8'd0, 8'h40); model_write(BASE + 8'd0, 8'h40, 0, ewe, ea, ed);
        bus_write(BASE + 8'd1, 8'h40); model_write(BASE + 8'd1, 8'h40, 0, ewe, ea, ed);
        bus_write(BASE + 8'd2, 8'h01); model_write(BASE + 8'd2, 8'h01, 0, ewe, ea, ed);
        checks++; if (fb_we_o !== ewe) begin errors++; $display("FAIL pixel_we got %b want %b", fb_we_o, ewe); end
        checks++; if (fb_addr_o !== ADDR_W'(ea)) begin errors++; $display("FAIL pixel_addr got %h want %h", fb_addr_o, ADDR_W'(ea)); end
        checks++; if (fb_data_o !== PIX_W'(ed)) begin errors++; $display("FAIL pixel_data got %h want %h", fb_data_o, PIX_W'(ed)); end
        @(posedge clk); #1;
        checks++; if (fb_we_o !== 1'b0) begin errors++; $display("FAIL pixel_pulse got %b want 0", fb_we_o); end
        bus_write(BASE + 8'd2, 8'h00); model_write(BASE + 8'd2, 8'h00, 0, ewe, ea, ed);
        checks++; if (fb_addr_o !== ADDR_W'(ea)) begin errors++; $display("FAIL pixel_x_hold got %h want %h", fb_addr_o, ADDR_W'(ea)); end
    endtask

    task automatic test_auto_inc();
        bit ewe; int ea, ed;
        bus_write(BASE + 8'd3, 8'h01); model_write(BASE + 8'd3, 8'h01, 0, ewe, ea, ed);
        bus_write(BASE + 8'd0, 8'hFE); model_write(BASE + 8'd0, 8'hFE, 0, ewe, ea, ed);
        bus_write(BASE + 8'd1, 8'h7F); model_write(BASE + 8'd1, 8'h7F, 0, ewe, ea, ed);
        for (int i = 0; i < 4; i++) begin
            bus_write(BASE + 8'd2, 8'h01); model_write(BASE + 8'd2, 8'h01, 0, ewe, ea, ed);
            checks++;
            if (fb_we_o !== 1'b1 || fb_addr_o !== ADDR_W'(ea)) begin
                errors++;
                $display("FAIL auto_inc_%0d got we=%b addr=%h want we=1 addr=%h", i, fb_we_o, fb_addr_o, ADDR_W'(ea));
            end
        end
    endtask

    task automatic test_back_to_back();
        bit ewe; int ea, ed;
        logic [7:0] d;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            d = 8'($urandom);
            bus_addr = BASE + 8'd2; bus_data = d; bus_we = 1'b1;
            @(posedge clk); #1;
            model_write(BASE + 8'd2, d, 0, ewe, ea, ed);
            checks++;
            if (fb_we_o !== 1'b1 || fb_addr_o !== ADDR_W'(ea) || fb_data_o !== PIX_W'(ed)) begin
                errors++;
                $display("FAIL b2b_%0d got we=%b addr=%h data=%h want 1 %h %h", i, fb_we_o, fb_addr_o, fb_data_o, ADDR_W'(ea), PIX_W'(ed));
            end
        end
        bus_we = 1'b0;
        @(posedge clk); #1;
        checks++; if (fb_we_o !== 1'b0) begin errors++; $display("FAIL b2b_end got %b want 0", fb_we_o); end
    endtask

    task automatic test_colour();
        bit ewe; int ea, ed;
        bus_write(BASE + 8'd4, 8'hAA); model_write(BASE + 8'd4, 8'hAA, 0, ewe, ea, ed);
        checks++; if (config_colours_o !== mcol) begin errors++; $display("FAIL colour_lo got %h want %h", config_colours_o, mcol); end
        bus_write(BASE + 8'd5, 8'h55); model_write(BASE + 8'd5, 8'h55, 0, ewe, ea, ed);
        checks++; if (config_colours_o !== mcol) begin errors++; $display("FAIL colour_hi got %h want %h", config_colours_o, mcol); end
        bus_write(BASE + 8'd7, 8'hFF); model_write(BASE + 8'd7, 8'hFF, 0, ewe, ea, ed);
        bus_write(BASE - 8'd1, 8'hFF); model_write(BASE - 8'd1, 8'hFF, 0, ewe, ea, ed);
        checks++;
        if (config_colours_o !== mcol || fb_we_o !== 1'b0) begin
            errors++;
            $display("FAIL outside_window got col=%h we=%b want col=%h we=0", config_colours_o, fb_we_o, mcol);
        end
        bus_write(BASE + 8'd2, 8'h01); model_write(BASE + 8'd2, 8'h01, 0, ewe, ea, ed);
        checks++; if (fb_addr_o !== ADDR_W'(ea)) begin errors++; $display("FAIL outside_window_xy got %h want %h", fb_addr_o, ADDR_W'(ea)); end
    endtask

    task automatic test_random();
        bit ewe; int ea, ed;
        logic [7:0] a, d;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 9) == 0) a = 8'($urandom);
            else                           a = BASE + 8'($urandom_range(0, 8));
            d = 8'($urandom);
            if (a == BASE + 8'd3) d[1] = 1'b0;
            if ($urandom_range(0, 4) == 0) begin
                @(posedge clk); #1;
                checks++; if (fb_we_o !== 1'b0) begin errors++; $display("FAIL rand_idle_%0d got we=%b want 0", i, fb_we_o); end
            end
            bus_write(a, d); model_write(a, d, 0, ewe, ea, ed);
            checks++;
            if (fb_we_o !== ewe || (ewe && (fb_addr_o !== ADDR_W'(ea) || fb_data_o !== PIX_W'(ed)))
                || config_colours_o !== mcol || busy_o !== 1'b0) begin
                errors++;
                $display("FAIL rand_%0d a=%h d=%h got we=%b addr=%h data=%h col=%h want we=%b addr=%h data=%h col=%h",
                         i, a, d, fb_we_o, fb_addr_o, fb_data_o, config_colours_o, ewe, ADDR_W'(ea), PIX_W'(ed), mcol);
            end
        end
    endtask

    task automatic test_clear();
        bit ewe; int ea, ed;
        int cnt, bad, colbad, first_bad, fill_snap;
        bus_write(BASE + 8'd6, 8'h01); model_write(BASE + 8'd6, 8'h01, 0, ewe, ea, ed);
        fill_snap = mfill;
        bus_write(BASE + 8'd3, 8'h02); model_write(BASE + 8'd3, 8'h02, 0, ewe, ea, ed);
        cnt = 0; bad = 0; colbad = 0; first_bad = -1;
        while (busy_o === 1'b1 && cnt < NPIX + 100) begin
            if (fb_addr_o !== ADDR_W'(cnt) || fb_we_o !== 1'b1 || fb_data_o !== PIX_W'(fill_snap)) begin
                if (first_bad < 0) first_bad = cnt;
                bad++;
            end
            if (config_colours_o !== mcol) colbad++;
            cnt++;
            @(negedge clk);
            bus_we = 1'b0;
            case (cnt)
                1000: begin bus_addr = BASE + 8'd2; bus_data = 8'h01; end
                2000: begin bus_addr = BASE + 8'd4; bus_data = 8'h5A; end
                2001: begin bus_addr = BASE + 8'd5; bus_data = 8'hA5; end
                3000: begin bus_addr = BASE + 8'd6; bus_data = 8'h00; end
                4000: begin bus_addr = BASE + 8'd3; bus_data = 8'h03; end
                5000: begin bus_addr = BASE + 8'd0; bus_data = 8'h10; end
                5001: begin bus_addr = BASE + 8'd1; bus_data = 8'h20; end
                default: ;
            endcase
            if (cnt == 1000 || cnt == 2000 || cnt == 2001 || cnt == 3000 || cnt == 4000 || cnt == 5000 || cnt == 5001) begin
                bus_we = 1'b1;
                model_write(bus_addr, bus_data, 1, ewe, ea, ed);
            end
            @(posedge clk); #1;
        end
        bus_we = 1'b0;
        checks++; if (cnt != NPIX) begin errors++; $display("FAIL clear_busy_len got %0d want %0d", cnt, NPIX); end
        checks++; if (bad != 0) begin errors++; $display("FAIL clear_sweep got %0d bad cycles (first at %0d) want 0", bad, first_bad); end
        checks++; if (colbad != 0) begin errors++; $display("FAIL clear_colours got %0d bad cycles want 0", colbad); end
        checks++;
        if (fb_we_o !== 1'b0 || busy_o !== 1'b0 || config_colours_o !== mcol) begin
            errors++;
            $display("FAIL clear_end got we=%b busy=%b col=%h want 0 0 %h", fb_we_o, busy_o, config_colours_o, mcol);
        end
        for (int i = 0; i < 2; i++) begin
            bus_write(BASE + 8'd2, 8'h01); model_write(BASE + 8'd2, 8'h01, 0, ewe, ea, ed);
            checks++;
            if (fb_we_o !== 1'b1 || fb_addr_o !== ADDR_W'(ea)) begin
                errors++;
                $display("FAIL clear_after_pix_%0d got we=%b addr=%h want 1 %h", i, fb_we_o, fb_addr_o, ADDR_W'(ea));
            end
        end
    endtask

    task automatic test_reset_mid_sweep();
        bit ewe; int ea, ed;
        int cyc, spurious;
        bus_write(BASE + 8'd6, 8'h01); model_write(BASE + 8'd6, 8'h01, 0, ewe, ea, ed);
        bus_write(BASE + 8'd3, 8'h02); model_write(BASE + 8'd3, 8'h02, 0, ewe, ea, ed);
        cyc = 0;
        while (fb_addr_o !== ADDR_W'(100) && cyc < 1000) begin
            @(posedge clk); #1;
            cyc++;
        end
        checks++; if (cyc >= 1000) begin errors++; $display("FAIL midreset_reach got addr=%h want 0064", fb_addr_o); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy_o !== 1'b0 || fb_we_o !== 1'b0 || fb_addr_o !== '0 || config_colours_o !== 16'h33CC) begin
            errors++;
            $display("FAIL midreset_outputs got busy=%b we=%b addr=%h col=%h want 0 0 0 33cc", busy_o, fb_we_o, fb_addr_o, config_colours_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        spurious = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (fb_we_o !== 1'b0 || busy_o !== 1'b0) spurious++;
        end
        checks++; if (spurious != 0) begin errors++; $display("FAIL midreset_resume got %0d active cycles want 0", spurious); end
        bus_write(BASE + 8'd0, 8'h03); model_write(BASE + 8'd0, 8'h03, 0, ewe, ea, ed);
        bus_write(BASE + 8'd1, 8'h05); model_write(BASE + 8'd1, 8'h05, 0, ewe, ea, ed);
        bus_write(BASE + 8'd2, 8'h01); model_write(BASE + 8'd2, 8'h01, 0, ewe, ea, ed);
        checks++;
        if (fb_we_o !== 1'b1 || fb_addr_o !== ADDR_W'(ea) || fb_data_o !== PIX_W'(ed)) begin
            errors++;
            $display("FAIL midreset_pixel got we=%b addr=%h data=%h want 1 %h %h", fb_we_o, fb_addr_o, fb_data_o, ADDR_W'(ea), PIX_W'(ed));
        end
    endtask

    initial begin
        rst_n = 1'b0;
        bus_addr = '0; bus_data = '0; bus_we = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        test_reset();
        test_pixel();
        test_auto_inc();
        test_back_to_back();
        test_colour();
        test_random();
        test_clear();
        test_reset_mid_sweep();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
